// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width, default data width and opcode encodings.
// Imported by the issuer, the pipelined ALU and their benches.
package alu_pkg;

   localparam int OPCODE_W   = 2;
   localparam int ALU_DATA_W = 8;

   localparam logic [OPCODE_W-1:0] OP_0 = 2'd0;
   localparam logic [OPCODE_W-1:0] OP_1 = 2'd1;
   localparam logic [OPCODE_W-1:0] OP_2 = 2'd2;
   localparam logic [OPCODE_W-1:0] OP_3 = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is visible on rdata.
// Callers gate push on not-full and pop on not-empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;

   // Storage, wrapping pointers and occupancy; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Front-end for the pipelined ALU: queues commands, issues them credit-gated onto the
// ALU ports, tags each through the fixed ALU latency and queues results for the consumer.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int DATA_W      = ALU_DATA_W,
   parameter int CMD_DEPTH   = 4,
   parameter int RSP_DEPTH   = 4,
   parameter int ALU_LATENCY = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [OPCODE_W-1:0] cmd_opcode,
   input  logic [DATA_W-1:0]   cmd_a,
   input  logic [DATA_W-1:0]   cmd_b,
   output logic [OPCODE_W-1:0] alu_opcode,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   input  logic [DATA_W-1:0]   alu_result,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_result,
   output logic [OPCODE_W-1:0] rsp_opcode,
   output logic                busy
);

   localparam int CMD_W  = OPCODE_W + 2 * DATA_W;
   localparam int RSP_W  = DATA_W + OPCODE_W;
   localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
   localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;
   localparam int INF_CW = $clog2(ALU_LATENCY + 1);
   localparam int SUM_W  = $clog2(RSP_DEPTH + ALU_LATENCY + 1) + 1;

   function automatic logic [INF_CW-1:0] popcount(input logic [ALU_LATENCY-1:0] v);
      logic [INF_CW-1:0] n;
      n = {INF_CW{1'b0}};
      for (int i = 0; i < ALU_LATENCY; i++) begin
         n = n + INF_CW'(v[i]);
      end
      return n;
   endfunction

   logic [CMD_CW-1:0]                     cmd_count_s;
   logic [CMD_W-1:0]                      cmd_head_s;
   logic                                  cmd_push_s;
   logic [RSP_CW-1:0]                     rsp_count_s;
   logic [RSP_W-1:0]                      rsp_head_s;
   logic                                  rsp_push_s;
   logic                                  rsp_pop_s;
   logic [INF_CW-1:0]                     inflight_s;
   logic [SUM_W-1:0]                      credit_use_s;
   logic                                  issue_s;
   logic [ALU_LATENCY-1:0]                tag_valid_r;
   logic [ALU_LATENCY-1:0][OPCODE_W-1:0]  tag_op_r;

   assign cmd_ready  = (cmd_count_s != CMD_CW'(CMD_DEPTH));
   assign cmd_push_s = cmd_valid && cmd_ready;

   sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_push_s),
      .pop   (issue_s),
      .wdata ({cmd_opcode, cmd_a, cmd_b}),
      .rdata (cmd_head_s),
      .count (cmd_count_s)
   );

   // Issue only while every in-flight op plus every queued response still fits in the response FIFO.
   always_comb begin
      inflight_s   = popcount(tag_valid_r);
      credit_use_s = SUM_W'(inflight_s) + SUM_W'(rsp_count_s);
      issue_s      = (cmd_count_s != {CMD_CW{1'b0}}) && (credit_use_s < SUM_W'(RSP_DEPTH));
   end

   // ALU operand registers; a bubble drives zeros.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_opcode <= OP_0;
         alu_a      <= {DATA_W{1'b0}};
         alu_b      <= {DATA_W{1'b0}};
      end else if (issue_s) begin
         alu_opcode <= cmd_head_s[CMD_W-1 -: OPCODE_W];
         alu_a      <= cmd_head_s[2*DATA_W-1 -: DATA_W];
         alu_b      <= cmd_head_s[DATA_W-1:0];
      end else begin
         alu_opcode <= OP_0;
         alu_a      <= {DATA_W{1'b0}};
         alu_b      <= {DATA_W{1'b0}};
      end
   end

   // Tag shift register mirroring the ALU pipeline; the last stage lines up with alu_result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_valid_r <= {ALU_LATENCY{1'b0}};
         tag_op_r    <= {(ALU_LATENCY*OPCODE_W){1'b0}};
      end else begin
         for (int i = ALU_LATENCY - 1; i > 0; i--) begin
            tag_valid_r[i] <= tag_valid_r[i-1];
            tag_op_r[i]    <= tag_op_r[i-1];
         end
         tag_valid_r[0] <= issue_s;
         tag_op_r[0]    <= issue_s ? cmd_head_s[CMD_W-1 -: OPCODE_W] : OP_0;
      end
   end

   assign rsp_push_s = tag_valid_r[ALU_LATENCY-1];
   assign rsp_pop_s  = rsp_valid && rsp_ready;

   sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rsp_push_s),
      .pop   (rsp_pop_s),
      .wdata ({alu_result, tag_op_r[ALU_LATENCY-1]}),
      .rdata (rsp_head_s),
      .count (rsp_count_s)
   );

   assign rsp_valid  = (rsp_count_s != {RSP_CW{1'b0}});
   assign rsp_result = rsp_head_s[RSP_W-1 -: DATA_W];
   assign rsp_opcode = rsp_head_s[OPCODE_W-1:0];
   assign busy       = (cmd_count_s != {CMD_CW{1'b0}}) || (inflight_s != {INF_CW{1'b0}})
                       || (rsp_count_s != {RSP_CW{1'b0}});

endmodule
